lzrw1_decomp_sequencer: RTL and testbench
=========================================

# lzrw1_decomp_sequencer

Front-end controller for the LZRW1 decompressor core: it accepts the raw compressed word stream, separates control words from items, and sequences items one at a time into the decompressor's `data_in`/`control_word_in`/`data_in_valid` port, honouring `decompressor_busy`. It also rejects malformed copy items before they reach the history buffer. It sits between the input FIFO / bus adapter and the decompressor core.

## Interface
- `GROUP_SIZE`, 16, number of items governed by one control word (1..16); control bit i governs item i.
- `STAT_WIDTH`, 32, width of the statistics counters (only used when stats are compiled in).

- `clock`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `in_word`  in  16  compressed stream word (control word or item).
- `in_valid`  in  1  `in_word` is valid.
- `in_last`  in  1  `in_word` is the final word of the compressed block.
- `in_ready`  out  1  sequencer accepts `in_word` this cycle.
- `dec_data`  out  16  item to the decompressor: literal in [7:0], or {length[15:12], offset[11:0]}.
- `dec_control_word`  out  1  1 = copy item, 0 = literal.
- `dec_data_valid`  out  1  single-cycle issue strobe.
- `dec_busy`  in  1  decompressor busy; no issue while high.
- `block_done`  out  1  one-cycle pulse when the last item of a block has been issued or dropped.
- `bad_item`  out  1  one-cycle pulse when a copy item is dropped.
- `err_sticky`  out  1  set by `bad_item`; cleared only by reset.
- `idle`  out  1  high in S_CTRL with no item pending.

## Operation
- Input handshake: transfer occurs when `in_valid && in_ready`. `in_ready` is combinational from state: 1 in S_CTRL and S_ITEM, 0 in S_ISSUE.
- States:
  - S_CTRL (reset state): on transfer, `ctrl_reg <= in_word`, `bit_idx <= 0`.
    - If `in_last`: pulse `block_done`, stay in S_CTRL (empty block).
    - Otherwise go to S_ITEM.
  - S_ITEM: on transfer, `item_reg <= in_word`, `kind_reg <= ctrl_reg[bit_idx]`, `last_reg <= in_last`.
    - If the item is a copy with `length == 0` or `offset == 0`: pulse `bad_item`, set `err_sticky`, drop the item and apply the advance rule.
    - Otherwise go to S_ISSUE.
  - S_ISSUE: `dec_data_valid = !dec_busy`, combinational. `dec_data`/`dec_control_word` are driven from `item_reg`/`kind_reg` in every state. On the issue cycle, apply the advance rule.
- Advance rule, checked in order:
  1. If `last_reg`: pulse `block_done` and go to S_CTRL.
  2. Else if `bit_idx == GROUP_SIZE-1`: go to S_CTRL.
  3. Else `bit_idx <= bit_idx + 1` and go to S_ITEM.
- Control bits beyond the item where `in_last` occurs are ignored.
- `bit_idx` is `$clog2(GROUP_SIZE)` bits wide (minimum 1) and never wraps past `GROUP_SIZE-1`.
- No combinational loop exists: `dec_busy` does not depend on `dec_data_valid`.

## Timing
- Reset values: `in_ready`=1, `dec_data`=0, `dec_control_word`=0, `dec_data_valid`=0, `block_done`=0, `bad_item`=0, `err_sticky`=0, `idle`=1. All registers are cleared.
- Item accepted in cycle N → earliest issue in cycle N+1 (when `dec_busy`=0 in N+1).
- After an issue the decompressor raises `dec_busy` in the next cycle, so issues are never back-to-back. The sequencer also needs at least one S_ITEM cycle between issues.
- `dec_data`/`dec_control_word` are stable for the whole of S_ISSUE.
- A dropped item costs one cycle and causes no issue.
- Reset in any state, including mid-S_ISSUE: return to S_CTRL immediately. A pending item is discarded and never issued.
- `block_done` and `bad_item` are both pulsed in the same cycle when the dropped item is the last item of a block.

## Configuration
- `LZRW1_SEQ_STATS_EN` defined: adds outputs `lit_count`, `copy_count`, `drop_count` (each `STAT_WIDTH` bits, reset 0).
  - `lit_count` increments on each issued literal; `copy_count` on each issued copy; `drop_count` on each `bad_item`.
  - Counters saturate at all-ones.
- Not defined: those ports and their counters do not exist. All other behaviour is identical.

## Structure
- Shared package `lzrw1_pkg`: `compressed_t` ({length[3:0], offset[11:0]}), `data_in_t` union, the sequencer state enum, and the default group size constant `LZRW1_GROUP_SIZE`=16.
- Sub-module `lzrw1_seq_stats`: the three saturating counters, instantiated only under `LZRW1_SEQ_STATS_EN`.

## Test plan
- Control word 0x0000, items 0x0041, 0x0042 (`in_last` on the 2nd item), `dec_busy` tied 0 → two issues with `dec_control_word`=0 and `dec_data` 0x0041 then 0x0042; `block_done` pulses on the 2nd issue cycle.
- Control word 0x0002, items 0x0061, 0x3001 (last) → the second issue has `dec_control_word`=1 and `dec_data`=0x3001. Holding `dec_busy`=1 for 5 cycles delays the issue until `dec_busy`=0, with `in_ready`=0 throughout.
- Copy item 0x0005 (length 0) and copy item 0x4000 (offset 0) → each is dropped, `bad_item` pulses, `err_sticky`=1, no `dec_data_valid`.
- 17 full items (control word, 16 items, new control word 0xFFFF, one item 0x2002 last) → the new control word is accepted after the 16th item; the 17th issue is a copy.
- Control word with `in_last` → `block_done` the same cycle, zero issues.
- Reset asserted in S_ISSUE → pending item is never issued, `idle`=1; with stats compiled in, counters read 0.

Source files
------------

// File: rtl/lzrw1_pkg.sv
// Shared LZRW1 types: compressed item layout, stream word union,
// sequencer state encoding and the default control-word group size.
package lzrw1_pkg;

    localparam int LZRW1_GROUP_SIZE = 16;

    typedef struct packed {
        logic [3:0]  length;
        logic [11:0] offset;
    } compressed_t;

    typedef struct packed {
        logic [7:0] pad;
        logic [7:0] literal;
    } literal_t;

    typedef union packed {
        compressed_t copy;
        literal_t    lit;
        logic [15:0] raw;
    } data_in_t;

    typedef enum logic [1:0] {
        S_CTRL  = 2'd0,
        S_ITEM  = 2'd1,
        S_ISSUE = 2'd2
    } seq_state_t;

    // A copy with zero length or zero offset would corrupt the history buffer.
    function automatic logic is_malformed_copy(input compressed_t c);
        return (c.length == 4'd0) || (c.offset == 12'd0);
    endfunction

endpackage

// File: rtl/lzrw1_decomp_sequencer_if.sv
// Stream-side and decompressor-side handshake bundle for the LZRW1 sequencer.
// master = environment (input FIFO + decompressor core), slave = sequencer.
interface lzrw1_decomp_sequencer_if;
    import lzrw1_pkg::*;

    data_in_t in_word;
    logic     in_valid;
    logic     in_last;
    logic     in_ready;
    data_in_t dec_data;
    logic     dec_control_word;
    logic     dec_data_valid;
    logic     dec_busy;

    modport master (
        output in_word, in_valid, in_last, dec_busy,
        input  in_ready, dec_data, dec_control_word, dec_data_valid
    );

    modport slave (
        input  in_word, in_valid, in_last, dec_busy,
        output in_ready, dec_data, dec_control_word, dec_data_valid
    );

endinterface

// File: rtl/lzrw1_seq_stats.sv
// Saturating issue/drop counters for the LZRW1 sequencer.
// Only instantiated when LZRW1_SEQ_STATS_EN is defined.
module lzrw1_seq_stats
    import lzrw1_pkg::*;
#(
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  lit_issue,
    input  logic                  copy_issue,
    input  logic                  drop,
    output logic [STAT_WIDTH-1:0] lit_count,
    output logic [STAT_WIDTH-1:0] copy_count,
    output logic [STAT_WIDTH-1:0] drop_count
);

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + STAT_WIDTH'(1);
    endfunction

    // Count events, holding each counter at all-ones once it gets there.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lit_count  <= '0;
            copy_count <= '0;
            drop_count <= '0;
        end else begin
            if (lit_issue)  lit_count  <= sat_inc(lit_count);
            if (copy_issue) copy_count <= sat_inc(copy_count);
            if (drop)       drop_count <= sat_inc(drop_count);
        end
    end

endmodule

// File: rtl/lzrw1_decomp_sequencer.sv
// LZRW1 decompressor front-end: splits the compressed stream into control
// words and items, drops malformed copies, and issues one item at a time
// to the decompressor core while honouring its busy signal.
// Optional statistics counters: define LZRW1_SEQ_STATS_EN.
module lzrw1_decomp_sequencer
    import lzrw1_pkg::*;
#(
    parameter int GROUP_SIZE = LZRW1_GROUP_SIZE,
    parameter int STAT_WIDTH = 32
) (
    input  logic clock,
    input  logic reset,
    lzrw1_decomp_sequencer_if.slave bus,
    output logic block_done,
    output logic bad_item,
    output logic err_sticky,
    output logic idle
`ifdef LZRW1_SEQ_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] lit_count,
    output logic [STAT_WIDTH-1:0] copy_count,
    output logic [STAT_WIDTH-1:0] drop_count
`endif
);

    localparam int IDX_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_SIZE - 1);

    if (GROUP_SIZE < 1 || GROUP_SIZE > 16 || STAT_WIDTH < 1) begin : g_param_check
        $error("lzrw1_decomp_sequencer: GROUP_SIZE must be 1..16 and STAT_WIDTH >= 1");
    end

    seq_state_t       state, state_next;
    logic [15:0]      ctrl_reg;
    logic [IDX_W-1:0] bit_idx, idx_next;
    data_in_t         item_reg;
    logic             kind_reg;
    logic             last_reg;

    logic ready;
    logic issue;
    logic load_ctrl;
    logic load_item;
    logic item_kind;
    logic do_advance;
    logic adv_last;

    assign item_kind = ctrl_reg[bit_idx];

    // State and group position register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_CTRL;
            bit_idx <= '0;
        end else begin
            state   <= state_next;
            bit_idx <= idx_next;
        end
    end

    // Capture control words and items as they are accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_reg <= '0;
            item_reg <= '0;
            kind_reg <= 1'b0;
            last_reg <= 1'b0;
        end else begin
            if (load_ctrl) ctrl_reg <= bus.in_word.raw;
            if (load_item) begin
                item_reg <= bus.in_word;
                kind_reg <= item_kind;
                last_reg <= bus.in_last;
            end
        end
    end

    // Malformed-copy flag stays set until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)         err_sticky <= 1'b0;
        else if (bad_item) err_sticky <= 1'b1;
    end

    // Next state, handshake and pulse generation; a drop and an issue both
    // finish the current item through the same advance logic.
    always_comb begin
        state_next = state;
        idx_next   = bit_idx;
        ready      = 1'b0;
        issue      = 1'b0;
        load_ctrl  = 1'b0;
        load_item  = 1'b0;
        block_done = 1'b0;
        bad_item   = 1'b0;
        do_advance = 1'b0;
        adv_last   = 1'b0;

        unique case (state)
            S_CTRL: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    load_ctrl = 1'b1;
                    idx_next  = '0;
                    if (bus.in_last) block_done = 1'b1;
                    else             state_next = S_ITEM;
                end
            end
            S_ITEM: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    load_item = 1'b1;
                    if (item_kind && is_malformed_copy(bus.in_word.copy)) begin
                        bad_item   = 1'b1;
                        do_advance = 1'b1;
                        adv_last   = bus.in_last;
                    end else begin
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                issue = !bus.dec_busy;
                if (!bus.dec_busy) begin
                    do_advance = 1'b1;
                    adv_last   = last_reg;
                end
            end
            default: state_next = S_CTRL;
        endcase

        if (do_advance) begin
            if (adv_last) begin
                block_done = 1'b1;
                state_next = S_CTRL;
            end else if (bit_idx == LAST_IDX) begin
                state_next = S_CTRL;
            end else begin
                idx_next   = bit_idx + IDX_W'(1);
                state_next = S_ITEM;
            end
        end
    end

    assign bus.in_ready         = ready;
    assign bus.dec_data         = item_reg;
    assign bus.dec_control_word = kind_reg;
    assign bus.dec_data_valid   = issue;
    assign idle                 = (state == S_CTRL);

`ifdef LZRW1_SEQ_STATS_EN
    lzrw1_seq_stats #(
        .STAT_WIDTH (STAT_WIDTH)
    ) u_stats (
        .clock      (clock),
        .reset      (reset),
        .lit_issue  (issue && !kind_reg),
        .copy_issue (issue && kind_reg),
        .drop       (bad_item),
        .lit_count  (lit_count),
        .copy_count (copy_count),
        .drop_count (drop_count)
    );
`endif

endmodule

// File: tb/tb_lzrw1_decomp_sequencer.sv
// Directed bench for lzrw1_decomp_sequencer. Inputs change 1 ns after the
// rising edge; outputs are sampled 2 ns after the rising edge.
module tb_lzrw1_decomp_sequencer;
    import lzrw1_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic block_done, bad_item, err_sticky, idle;
`ifdef LZRW1_SEQ_STATS_EN
    logic [31:0] lit_count, copy_count, drop_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    lzrw1_decomp_sequencer_if bus();

    always #5 clock = ~clock;

    lzrw1_decomp_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .block_done (block_done),
        .bad_item   (bad_item),
        .err_sticky (err_sticky),
        .idle       (idle)
`ifdef LZRW1_SEQ_STATS_EN
        ,
        .lit_count  (lit_count),
        .copy_count (copy_count),
        .drop_count (drop_count)
`endif
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] w, input logic l);
        bus.in_valid = v;
        bus.in_word  = w;
        bus.in_last  = l;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        bus.dec_busy = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        bus.dec_busy = 1'b0;
        #2;
        tests_run++;
        if ({bus.in_ready, idle} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_ready_idle: got %b want 11", {bus.in_ready, idle});
        end
        tests_run++;
        if ({bus.dec_data, bus.dec_control_word, bus.dec_data_valid} !== 18'h0) begin
            tests_failed++;
            $display("FAIL reset_dec_port: got %h want 00000", {bus.dec_data, bus.dec_control_word, bus.dec_data_valid});
        end
        tests_run++;
        if ({block_done, bad_item, err_sticky} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 000", {block_done, bad_item, err_sticky});
        end
    endtask

    task automatic test_literals();
        apply_reset();
        drive(1'b1, 16'h0000, 1'b0); #1;
        tests_run++;
        if ({bus.in_ready, idle} !== 2'b11) begin
            tests_failed++;
            $display("FAIL lit_ctrl_accept: got %b want 11", {bus.in_ready, idle});
        end
        step(); drive(1'b1, 16'h0041, 1'b0); #1;
        tests_run++;
        if ({bus.in_ready, bus.dec_data_valid, idle} !== 3'b100) begin
            tests_failed++;
            $display("FAIL lit_item0_accept: got %b want 100", {bus.in_ready, bus.dec_data_valid, idle});
        end
        step(); drive(1'b0, 16'h0000, 1'b0); #1;
        tests_run++;
        if ({bus.dec_data_valid, bus.dec_control_word, bus.dec_data, block_done, bus.in_ready} !== {1'b1, 1'b0, 16'h0041, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL lit_issue0: got %h want %h", {bus.dec_data_valid, bus.dec_control_word, bus.dec_data, block_done, bus.in_ready}, {1'b1, 1'b0, 16'h0041, 1'b0, 1'b0});
        end
        step(); drive(1'b1, 16'h0042, 1'b1); #1;
        tests_run++;
        if ({bus.in_ready, bus.dec_data_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL lit_item1_accept: got %b want 10", {bus.in_ready, bus.dec_data_valid});
        end
        step(); drive(1'b0, 16'h0000, 1'b0); #1;
        tests_run++;
        if ({bus.dec_data_valid, bus.dec_control_word, bus.dec_data, block_done} !== {1'b1, 1'b0, 16'h0042, 1'b1}) begin
            tests_failed++;
            $display("FAIL lit_issue1_done: got %h want %h", {bus.dec_data_valid, bus.dec_control_word, bus.dec_data, block_done}, {1'b1, 1'b0, 16'h0042, 1'b1});
        end
        step(); #1;
        tests_run++;
        if ({idle, bus.dec_data_valid, block_done} !== 3'b100) begin
            tests_failed++;
            $display("FAIL lit_back_idle: got %b want 100", {idle, bus.dec_data_valid, block_done});
        end
`ifdef LZRW1_SEQ_STATS_EN
        tests_run++;
        if ({lit_count, copy_count, drop_count} !== {32'd2, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL lit_stats: got %0d/%0d/%0d want 2/0/0", lit_count, copy_count, drop_count);
        end
`endif
    endtask

    task automatic test_copy_busy();
        apply_reset();
        drive(1'b1, 16'h0002, 1'b0); step();
        drive(1'b1, 16'h0061, 1'b0); step();
        drive(1'b0, 16'h0000, 1'b0); #1;
        tests_run++;
        if ({bus.dec_data_valid, bus.dec_control_word, bus.dec_data} !== {1'b1, 1'b0, 16'h0061}) begin
            tests_failed++;
            $display("FAIL copy_issue_lit: got %h want %h", {bus.dec_data_valid, bus.dec_control_word, bus.dec_data}, {1'b1, 1'b0, 16'h0061});
        end
        step(); drive(1'b1, 16'h3001, 1'b1); #1;
        tests_run++;
        if ({bus.in_ready, bad_item} !== 2'b10) begin
            tests_failed++;
            $display("FAIL copy_accept: got %b want 10", {bus.in_ready, bad_item});
        end
        step(); drive(1'b0, 16'h0000, 1'b0); bus.dec_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if ({bus.in_ready, bus.dec_data_valid, bus.dec_control_word, bus.dec_data, block_done} !== {1'b0, 1'b0, 1'b1, 16'h3001, 1'b0}) begin
                tests_failed++;
                $display("FAIL copy_busy_hold%0d: got %h want %h", i, {bus.in_ready, bus.dec_data_valid, bus.dec_control_word, bus.dec_data, block_done}, {1'b0, 1'b0, 1'b1, 16'h3001, 1'b0});
            end
            step();
        end
        bus.dec_busy = 1'b0; #1;
        tests_run++;
        if ({bus.dec_data_valid, bus.dec_control_word, bus.dec_data, block_done} !== {1'b1, 1'b1, 16'h3001, 1'b1}) begin
            tests_failed++;
            $display("FAIL copy_issue: got %h want %h", {bus.dec_data_valid, bus.dec_control_word, bus.dec_data, block_done}, {1'b1, 1'b1, 16'h3001, 1'b1});
        end
        step(); #1;
        tests_run++;
        if ({idle, bus.dec_data_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL copy_back_idle: got %b want 10", {idle, bus.dec_data_valid});
        end
`ifdef LZRW1_SEQ_STATS_EN
        tests_run++;
        if ({lit_count, copy_count, drop_count} !== {32'd1, 32'd1, 32'd0}) begin
            tests_failed++;
            $display("FAIL copy_stats: got %0d/%0d/%0d want 1/1/0", lit_count, copy_count, drop_count);
        end
`endif
    endtask

    task automatic test_drop();
        apply_reset();
        drive(1'b1, 16'hFFFF, 1'b0); step();
        drive(1'b1, 16'h0005, 1'b0); #1;
        tests_run++;
        if ({bad_item, bus.dec_data_valid, block_done, err_sticky} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL drop_len0: got %b want 1000", {bad_item, bus.dec_data_valid, block_done, err_sticky});
        end
        step(); drive(1'b1, 16'h4000, 1'b1); #1;
        tests_run++;
        if ({err_sticky, bus.in_ready, idle} !== 3'b110) begin
            tests_failed++;
            $display("FAIL drop_sticky_next_item: got %b want 110", {err_sticky, bus.in_ready, idle});
        end
        tests_run++;
        if ({bad_item, block_done, bus.dec_data_valid} !== 3'b110) begin
            tests_failed++;
            $display("FAIL drop_off0_last: got %b want 110", {bad_item, block_done, bus.dec_data_valid});
        end
        step(); drive(1'b0, 16'h0000, 1'b0); #1;
        tests_run++;
        if ({idle, bus.dec_data_valid, bad_item, err_sticky} !== 4'b1001) begin
            tests_failed++;
            $display("FAIL drop_after: got %b want 1001", {idle, bus.dec_data_valid, bad_item, err_sticky});
        end
`ifdef LZRW1_SEQ_STATS_EN
        tests_run++;
        if ({lit_count, copy_count, drop_count} !== {32'd0, 32'd0, 32'd2}) begin
            tests_failed++;
            $display("FAIL drop_stats: got %0d/%0d/%0d want 0/0/2", lit_count, copy_count, drop_count);
        end
`endif
    endtask

    task automatic test_full_group();
        logic [15:0] item;
        apply_reset();
        drive(1'b1, 16'h0000, 1'b0); step();
        for (int i = 0; i < 16; i++) begin
            item = 16'h0100 + 16'(i);
            drive(1'b1, item, 1'b0); #1;
            tests_run++;
            if ({bus.in_ready, idle} !== 2'b10) begin
                tests_failed++;
                $display("FAIL group_item%0d_accept: got %b want 10", i, {bus.in_ready, idle});
            end
            step(); drive(1'b0, 16'h0000, 1'b0); #1;
            tests_run++;
            if ({bus.dec_data_valid, bus.dec_control_word, bus.dec_data, block_done} !== {1'b1, 1'b0, item, 1'b0}) begin
                tests_failed++;
                $display("FAIL group_issue%0d: got %h want %h", i, {bus.dec_data_valid, bus.dec_control_word, bus.dec_data, block_done}, {1'b1, 1'b0, item, 1'b0});
            end
            step();
        end
        drive(1'b1, 16'hFFFF, 1'b0); #1;
        tests_run++;
        if ({idle, bus.in_ready, block_done} !== 3'b110) begin
            tests_failed++;
            $display("FAIL group_new_ctrl: got %b want 110", {idle, bus.in_ready, block_done});
        end
        step(); drive(1'b1, 16'h2002, 1'b1); step();
        drive(1'b0, 16'h0000, 1'b0); #1;
        tests_run++;
        if ({bus.dec_data_valid, bus.dec_control_word, bus.dec_data, block_done} !== {1'b1, 1'b1, 16'h2002, 1'b1}) begin
            tests_failed++;
            $display("FAIL group_issue16: got %h want %h", {bus.dec_data_valid, bus.dec_control_word, bus.dec_data, block_done}, {1'b1, 1'b1, 16'h2002, 1'b1});
        end
        step();
`ifdef LZRW1_SEQ_STATS_EN
        tests_run++;
        if ({lit_count, copy_count} !== {32'd16, 32'd1}) begin
            tests_failed++;
            $display("FAIL group_stats: got %0d/%0d want 16/1", lit_count, copy_count);
        end
`endif
    endtask

    task automatic test_empty_block();
        apply_reset();
        drive(1'b1, 16'h1234, 1'b1); #1;
        tests_run++;
        if ({block_done, bus.in_ready, idle, bus.dec_data_valid} !== 4'b1110) begin
            tests_failed++;
            $display("FAIL empty_done: got %b want 1110", {block_done, bus.in_ready, idle, bus.dec_data_valid});
        end
        step(); drive(1'b0, 16'h0000, 1'b0); #1;
        tests_run++;
        if ({idle, block_done, bus.dec_data_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL empty_after: got %b want 100", {idle, block_done, bus.dec_data_valid});
        end
    endtask

    task automatic test_reset_mid_issue();
        apply_reset();
        drive(1'b1, 16'h0000, 1'b0); step();
        drive(1'b1, 16'h0033, 1'b0); step();
        drive(1'b0, 16'h0000, 1'b0); #1;
        tests_run++;
        if ({bus.dec_data_valid, bus.dec_data} !== {1'b1, 16'h0033}) begin
            tests_failed++;
            $display("FAIL rst_first_issue: got %h want %h", {bus.dec_data_valid, bus.dec_data}, {1'b1, 16'h0033});
        end
        step(); bus.dec_busy = 1'b1;
        drive(1'b1, 16'h0055, 1'b0); step();
        drive(1'b0, 16'h0000, 1'b0); #1;
        tests_run++;
        if ({bus.dec_data_valid, bus.in_ready, idle, bus.dec_data} !== {1'b0, 1'b0, 1'b0, 16'h0055}) begin
            tests_failed++;
            $display("FAIL rst_pending: got %h want %h", {bus.dec_data_valid, bus.in_ready, idle, bus.dec_data}, {1'b0, 1'b0, 1'b0, 16'h0055});
        end
        #1; reset = 1'b1; #1;
        tests_run++;
        if ({idle, bus.in_ready, bus.dec_data_valid, bus.dec_data} !== {1'b1, 1'b1, 1'b0, 16'h0000}) begin
            tests_failed++;
            $display("FAIL rst_async_clear: got %h want %h", {idle, bus.in_ready, bus.dec_data_valid, bus.dec_data}, {1'b1, 1'b1, 1'b0, 16'h0000});
        end
`ifdef LZRW1_SEQ_STATS_EN
        tests_run++;
        if ({lit_count, copy_count, drop_count} !== 96'd0) begin
            tests_failed++;
            $display("FAIL rst_stats: got %0d/%0d/%0d want 0/0/0", lit_count, copy_count, drop_count);
        end
`endif
        step(); reset = 1'b0; bus.dec_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if ({bus.dec_data_valid, idle} !== 2'b01) begin
                tests_failed++;
                $display("FAIL rst_no_issue%0d: got %b want 01", i, {bus.dec_data_valid, idle});
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_literals();
        test_copy_busy();
        test_drop();
        test_full_group();
        test_empty_block();
        test_reset_mid_issue();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
